// File: rtl/gray_step_decoder.sv
// ---------------------------------------------------------------------------------------------
// gray_step_decoder
//
// Takes a Gray-coded position word from an unrelated timing domain, re-times it through a
// two-flop synchroniser, decodes it to binary and classifies every change as a single step up,
// a single step down or an illegal jump. Legal steps move a wrapping position accumulator and
// raise one-cycle strobes; an illegal jump parks the block in a sticky fault until cleared.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   G      - Gray-coded input word (asynchronous to clk)
//   en     - sample enable; when low, state, B and POS hold
//   clr    - synchronous fault clear; returns the block to IDLE, keeps B and POS
//   B      - registered decoded binary value
//   valid  - one-cycle pulse whenever B is (re)loaded
//   up     - one-cycle pulse on a +1 step (mod 2^N)
//   down   - one-cycle pulse on a -1 step (mod 2^N)
//   err    - sticky illegal-transition flag
//   POS    - wrapping step accumulator
// ---------------------------------------------------------------------------------------------
module gray_step_decoder #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] G,
    input  logic         en,
    input  logic         clr,
    output logic [N-1:0] B,
    output logic         valid,
    output logic         up,
    output logic         down,
    output logic         err,
    output logic [W-1:0] POS
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StTrack = 2'b01,
        StFault = 2'b10
    } state_e;

    state_e       r_state;
    state_e       w_state_nxt;

    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;
    logic [N-1:0] r_b;
    logic [W-1:0] r_pos;
    logic         r_valid;
    logic         r_up;
    logic         r_down;
    logic         r_err;

    logic [N-1:0] w_dec;
    logic [N-1:0] w_b_inc;
    logic [N-1:0] w_b_dec;
    logic [N-1:0] w_b_nxt;
    logic [W-1:0] w_pos_nxt;
    logic         w_valid_nxt;
    logic         w_up_nxt;
    logic         w_down_nxt;
    logic         w_err_nxt;

    // Two-flop synchroniser; runs every cycle independent of en and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= G;
            r_sync2 <= r_sync1;
        end
    end

    // Gray to binary: bit i is the XOR of all Gray bits at or above i. Shifting avoids a
    // self-referencing chain through w_dec.
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < N; i++) begin
            w_dec[i] = ^(r_sync2 >> i);
        end
    end

    // Neighbours of the current value; carries drop off so 15+1 -> 0 and 0-1 -> 15.
    assign w_b_inc = r_b + N'(1);
    assign w_b_dec = r_b - N'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        w_pos_nxt   = r_pos;
        w_valid_nxt = 1'b0;
        w_up_nxt    = 1'b0;
        w_down_nxt  = 1'b0;
        w_err_nxt   = r_err;

        if (clr) begin
            // Clear wins over everything else this cycle; B and POS are kept.
            w_err_nxt   = 1'b0;
            w_state_nxt = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (en) begin
                        w_b_nxt     = w_dec;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = StTrack;
                    end
                end
                StTrack: begin
                    if (en && (w_dec != r_b)) begin
                        if (w_dec == w_b_inc) begin
                            w_b_nxt     = w_dec;
                            w_valid_nxt = 1'b1;
                            w_up_nxt    = 1'b1;
                            w_pos_nxt   = r_pos + W'(1);
                        end else if (w_dec == w_b_dec) begin
                            w_b_nxt     = w_dec;
                            w_valid_nxt = 1'b1;
                            w_down_nxt  = 1'b1;
                            w_pos_nxt   = r_pos - W'(1);
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = StFault;
                        end
                    end
                end
                StFault: begin
                    // Parked until clr; input activity is ignored.
                    w_err_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_b     <= '0;
            r_pos   <= '0;
            r_valid <= 1'b0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_b     <= w_b_nxt;
            r_pos   <= w_pos_nxt;
            r_valid <= w_valid_nxt;
            r_up    <= w_up_nxt;
            r_down  <= w_down_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign B     = r_b;
    assign valid = r_valid;
    assign up    = r_up;
    assign down  = r_down;
    assign err   = r_err;
    assign POS   = r_pos;

endmodule

// File: tb/tb_gray_step_decoder.sv
// ---------------------------------------------------------------------------------------------
// tb_gray_step_decoder
//
// Self-checking bench for gray_step_decoder (N=4, W=8). A per-cycle vector table covers IDLE
// load, up/down steps, wrap in both directions, en gating, clr and a fault; hand-written
// sequences cover the slow walk, back-to-back steps, fault hold/clear and asynchronous reset.
// ---------------------------------------------------------------------------------------------
module tb_gray_step_decoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] G;
    logic       en;
    logic       clr;
    logic [3:0] B;
    logic       valid;
    logic       up;
    logic       down;
    logic       err;
    logic [7:0] POS;

    int n_checks;
    int n_errors;
    int n_up;
    int n_down;
    int n_valid;
    int n_both;

    gray_step_decoder #(
        .N(4),
        .W(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .G    (G),
        .en   (en),
        .clr  (clr),
        .B    (B),
        .valid(valid),
        .up   (up),
        .down (down),
        .err  (err),
        .POS  (POS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic       en;
        logic       clr;
        logic [3:0] b;
        logic       v;
        logic       u;
        logic       d;
        logic       e;
        logic [7:0] pos;
    } vec_t;

    vec_t vecs[26];

    function automatic logic [3:0] gray(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        n_up    += int'(up);
        n_down  += int'(down);
        n_valid += int'(valid);
        if (up && down) n_both++;
    endtask

    task automatic clr_counts();
        n_up    = 0;
        n_down  = 0;
        n_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        G     = 4'h0;
        en    = 1'b0;
        clr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_both   = 0;
        clr_counts();

        //            g      en    clr   b      v     u     d     e     pos
        vecs[0]  = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{4'h3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{4'h3, 1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[6]  = '{4'h3, 1'b1, 1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02};
        vecs[7]  = '{4'h1, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02};
        vecs[8]  = '{4'h1, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02};
        vecs[9]  = '{4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01};
        vecs[10] = '{4'h0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[11] = '{4'h8, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[12] = '{4'h8, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[13] = '{4'h8, 1'b1, 1'b0, 4'hf, 1'b1, 1'b0, 1'b1, 1'b0, 8'hff};
        vecs[14] = '{4'h8, 1'b1, 1'b0, 4'hf, 1'b0, 1'b0, 1'b0, 1'b0, 8'hff};
        vecs[15] = '{4'h0, 1'b0, 1'b0, 4'hf, 1'b0, 1'b0, 1'b0, 1'b0, 8'hff};
        vecs[16] = '{4'h0, 1'b0, 1'b0, 4'hf, 1'b0, 1'b0, 1'b0, 1'b0, 8'hff};
        vecs[17] = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[18] = '{4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[19] = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[20] = '{4'h7, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[21] = '{4'h7, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[22] = '{4'h7, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[23] = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[24] = '{4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[25] = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        // ---- Reset state ----
        do_reset();
        chk("rst_B", 32'(B), 32'h0);
        chk("rst_POS", 32'(POS), 32'h0);
        chk("rst_flags", {28'h0, valid, up, down, err}, 32'h0);

        // ---- Vector table ----
        for (int i = 0; i < 26; i++) begin
            G   = vecs[i].g;
            en  = vecs[i].en;
            clr = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d_B", i), 32'(B), 32'(vecs[i].b));
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].v));
            chk($sformatf("vec%0d_up", i), 32'(up), 32'(vecs[i].u));
            chk($sformatf("vec%0d_down", i), 32'(down), 32'(vecs[i].d));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].e));
            chk($sformatf("vec%0d_POS", i), 32'(POS), 32'(vecs[i].pos));
        end
        clr = 1'b0;

        // ---- Slow walk 0..15..0, one code every two cycles ----
        do_reset();
        G  = gray(0);
        en = 1'b1;
        repeat (3) tick();
        clr_counts();
        for (int k = 1; k <= 16; k++) begin
            G = gray(k % 16);
            tick();
            tick();
        end
        repeat (3) tick();
        chk("walk_nup", 32'(n_up), 32'd16);
        chk("walk_ndown", 32'(n_down), 32'd0);
        chk("walk_nvalid", 32'(n_valid), 32'd16);
        chk("walk_B", 32'(B), 32'h0);
        chk("walk_POS", 32'(POS), 32'd16);
        chk("walk_err", 32'(err), 32'h0);

        // ---- 0 -> 15 is a down step ----
        G = 4'b1000;
        tick();
        tick();
        tick();
        chk("wrapdn_down", 32'(down), 32'h1);
        chk("wrapdn_up", 32'(up), 32'h0);
        chk("wrapdn_B", 32'(B), 32'hf);
        chk("wrapdn_POS", 32'(POS), 32'd15);

        // ---- Back-to-back down steps, one Gray change per cycle ----
        clr_counts();
        for (int k = 14; k >= 11; k--) begin
            G = gray(k);
            tick();
        end
        repeat (3) tick();
        chk("b2b_ndown", 32'(n_down), 32'd4);
        chk("b2b_nup", 32'(n_up), 32'd0);
        chk("b2b_B", 32'(B), 32'd11);
        chk("b2b_POS", 32'(POS), 32'd11);

        // ---- Illegal jump 3 -> 5, fault hold, clr and reload ----
        do_reset();
        G  = gray(0);
        en = 1'b1;
        repeat (3) tick();
        for (int k = 1; k <= 3; k++) begin
            G = gray(k);
            tick();
            tick();
        end
        tick();
        chk("flt_pre_B", 32'(B), 32'd3);
        clr_counts();
        G = 4'b0111;
        tick();
        tick();
        tick();
        chk("flt_err", 32'(err), 32'h1);
        chk("flt_B", 32'(B), 32'd3);
        chk("flt_strobes", {29'h0, valid, up, down}, 32'h0);
        G = gray(4);
        repeat (3) tick();
        G = 4'b0111;
        repeat (3) tick();
        chk("flt_hold_err", 32'(err), 32'h1);
        chk("flt_hold_B", 32'(B), 32'd3);
        chk("flt_hold_nvalid", 32'(n_valid), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_err", 32'(err), 32'h0);
        chk("clr_valid", 32'(valid), 32'h0);
        tick();
        chk("reload_valid", 32'(valid), 32'h1);
        chk("reload_B", 32'(B), 32'd5);
        chk("reload_updown", {30'h0, up, down}, 32'h0);
        chk("reload_POS", 32'(POS), 32'd3);

        // ---- en low while G moves three codes, then enable: jump of +3 ----
        en = 1'b0;
        clr_counts();
        for (int k = 6; k <= 8; k++) begin
            G = gray(k);
            tick();
            tick();
        end
        repeat (2) tick();
        chk("en0_nvalid", 32'(n_valid), 32'd0);
        chk("en0_B", 32'(B), 32'd5);
        en = 1'b1;
        tick();
        chk("en1_err", 32'(err), 32'h1);
        chk("en1_B", 32'(B), 32'd5);
        chk("en1_valid", 32'(valid), 32'h0);

        // ---- Asynchronous reset mid-stream at B=9, POS=20 ----
        do_reset();
        G = gray(5);
        repeat (3) tick();
        en = 1'b1;
        tick();
        chk("ar_load_B", 32'(B), 32'd5);
        for (int k = 6; k <= 25; k++) begin
            G = gray(k % 16);
            tick();
        end
        repeat (2) tick();
        chk("ar_pre_B", 32'(B), 32'd9);
        chk("ar_pre_POS", 32'(POS), 32'd20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_B", 32'(B), 32'h0);
        chk("ar_POS", 32'(POS), 32'h0);
        chk("ar_flags", {28'h0, valid, up, down, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // Synchroniser restarts from 0, so IDLE reloads B=0 with a plain valid.
        chk("ar_idle_valid", 32'(valid), 32'h1);
        chk("ar_idle_B", 32'(B), 32'h0);
        chk("ar_idle_updown", {30'h0, up, down}, 32'h0);

        chk("never_up_and_down", 32'(n_both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
